// File: rtl/sustain_envelope_pkg.sv
// Shared definitions for the per-voice ADSR envelope: state encoding and gain limits.
package sustain_envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [7:0] GAIN_MAX = 8'd255;
  localparam int         SAMPLE_W = 16;
  localparam int         COUNT_W  = 16;

endpackage

// File: rtl/dffr.sv
// Codebase D flip-flop with synchronous active-high reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state always uses non-blocking assignment so every
  // flop samples its D input before any of them update.
  always_ff @(posedge clk) begin
    if (r) q <= '0;
    else   q <= d;
  end

endmodule

// File: rtl/sustain_envelope_scaler.sv
// Applies the envelope gain to a signed sample: (sample * gain) >>> 8, one cycle latency.
module sustain_envelope_scaler
  import sustain_envelope_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic [7:0]                 gain,
  output logic [SAMPLE_W-1:0]        sample_out,
  output logic                       sample_valid
);

  logic signed [24:0]         product;
  logic        [SAMPLE_W-1:0] out_d;

  // Gain is zero-extended to 9 bits so it multiplies as a positive value.
  always_comb begin
    product = 25'(sample_in) * 25'($signed({1'b0, gain}));
    out_d   = sample_tick ? 16'(product >>> 8) : sample_out;
  end

  dffr #(.W(SAMPLE_W)) u_out (
    .clk (clk),
    .r   (reset),
    .d   (out_d),
    .q   (sample_out)
  );

  dffr #(.W(1)) u_valid (
    .clk (clk),
    .r   (reset),
    .d   (sample_tick),
    .q   (sample_valid)
  );

endmodule

// File: rtl/sustain_envelope.sv
// Per-voice attack/decay/sustain/release envelope; steps only on sample ticks.
module sustain_envelope
  import sustain_envelope_pkg::*;
#(
  parameter logic [7:0] ATTACK_STEP   = 8'd32,
  parameter logic [7:0] DECAY_STEP    = 8'd8,
  parameter logic [7:0] SUSTAIN_LEVEL = 8'd160,
  parameter logic [7:0] RELEASE_STEP  = 8'd4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                note_start,
  input  logic [COUNT_W-1:0]  sustain_count,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic [7:0]          gain,
  output logic                busy,
  output logic                done
);

  logic [2:0]          state_q;
  env_state_t          state;
  env_state_t          state_d;
  logic [7:0]          gain_d;
  logic [COUNT_W-1:0]  counter;
  logic [COUNT_W-1:0]  counter_d;
  logic                done_d;
  logic [8:0]          attack_sum;
  logic signed [9:0]   decay_diff;

  assign state = env_state_t'(state_q);
  assign busy  = (state != ST_IDLE);

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    gain_d     = gain;
    counter_d  = counter;
    done_d     = 1'b0;
    attack_sum = {1'b0, gain} + {1'b0, ATTACK_STEP};
    decay_diff = $signed({2'b00, gain}) - $signed({2'b00, DECAY_STEP});

    // A retrigger keeps the current gain so the restart is click-free.
    if (note_start) begin
      state_d = ST_ATTACK;
    end else if (sample_tick) begin
      case (state)
        ST_IDLE: ;
        ST_ATTACK: begin
          if (attack_sum >= {1'b0, GAIN_MAX}) begin
            gain_d  = GAIN_MAX;
            state_d = ST_DECAY;
          end else begin
            gain_d = attack_sum[7:0];
          end
        end
        ST_DECAY: begin
          if (decay_diff <= $signed({2'b00, SUSTAIN_LEVEL})) begin
            gain_d    = SUSTAIN_LEVEL;
            counter_d = sustain_count;
            state_d   = ST_SUSTAIN;
          end else begin
            gain_d = decay_diff[7:0];
          end
        end
        ST_SUSTAIN: begin
          if (counter == '0) state_d = ST_RELEASE;
          else               counter_d = counter - 1'b1;
        end
        ST_RELEASE: begin
          if (gain <= RELEASE_STEP) begin
            gain_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            gain_d = gain - RELEASE_STEP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  dffr #(.W(3)) u_state (
    .clk (clk),
    .r   (reset),
    .d   (state_d),
    .q   (state_q)
  );

  dffr #(.W(8)) u_gain (
    .clk (clk),
    .r   (reset),
    .d   (gain_d),
    .q   (gain)
  );

  dffr #(.W(COUNT_W)) u_counter (
    .clk (clk),
    .r   (reset),
    .d   (counter_d),
    .q   (counter)
  );

  dffr #(.W(1)) u_done (
    .clk (clk),
    .r   (reset),
    .d   (done_d),
    .q   (done)
  );

  // The scaler sees the registered gain, i.e. the value before this tick's step.
  sustain_envelope_scaler u_scaler (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .sample_in    (sample_in),
    .gain         (gain),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

endmodule

// File: tb/tb_sustain_envelope.sv
// Self-checking bench for sustain_envelope: fixed vectors, directed note sequences, random traffic.
module tb_sustain_envelope;

  logic        clk = 1'b0;
  logic        reset;
  logic        note_start;
  logic [15:0] sustain_count;
  logic        sample_tick;
  logic [15:0] sample_in;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [7:0]  gain;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sustain_envelope dut (
    .clk           (clk),
    .reset         (reset),
    .note_start    (note_start),
    .sustain_count (sustain_count),
    .sample_tick   (sample_tick),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .gain          (gain),
    .busy          (busy),
    .done          (done)
  );

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Reference model: phase name, gain and sustain countdown as plain integers.
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
  int          m_phase = P_IDLE;
  int          m_gain  = 0;
  int          m_cnt   = 0;
  logic [15:0] m_out   = '0;
  logic        m_valid = 1'b0;
  logic        m_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    return 16'(p >>> 8);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step(input logic rst, input logic ns, input logic tk,
                            input logic [15:0] sin, input logic [15:0] sc);
    int g;
    g = m_gain;
    if (rst) begin
      m_phase = P_IDLE; m_gain = 0; m_cnt = 0;
      m_out = '0; m_valid = 1'b0; m_done = 1'b0;
      return;
    end
    m_valid = tk;
    m_done  = 1'b0;
    if (tk) m_out = ref_scale(sin, g);
    if (ns) begin
      m_phase = P_ATK;
    end else if (tk) begin
      case (m_phase)
        P_ATK: begin
          m_gain = imin(g + 32, 255);
          if (m_gain == 255) m_phase = P_DEC;
        end
        P_DEC: begin
          m_gain = imax(g - 8, 160);
          if (m_gain == 160) begin m_phase = P_SUS; m_cnt = int'(sc); end
        end
        P_SUS: begin
          if (m_cnt == 0) m_phase = P_REL;
          else            m_cnt--;
        end
        P_REL: begin
          m_gain = imax(g - 4, 0);
          if (m_gain == 0) begin m_phase = P_IDLE; m_done = 1'b1; end
        end
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, compare against the model.
  task automatic cyc(input logic rst, input logic ns, input logic tk,
                     input logic [15:0] sin, input logic [15:0] sc);
    reset = rst; note_start = ns; sample_tick = tk; sample_in = sin; sustain_count = sc;
    @(posedge clk);
    model_step(rst, ns, tk, sin, sc);
    #1;
    if (done === 1'b1) done_pulses++;
    check("gain",         32'(gain),         32'(m_gain));
    check("busy",         32'(busy),         32'(m_phase != P_IDLE));
    check("sample_valid", 32'(sample_valid), 32'(m_valid));
    check("done",         32'(done),         32'(m_done));
    check("sample_out",   32'(sample_out),   32'(m_out));
  endtask

  task automatic ticks(input int n, input logic [15:0] sc);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0100, sc);
  endtask

  typedef struct {
    logic        rst;
    logic        ns;
    logic        tk;
    logic [15:0] sin;
    logic [7:0]  e_gain;
    logic        e_busy;
    logic        e_valid;
    logic [15:0] e_out;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'd0,  1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h4000, 8'd0,  1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h4000, 8'd0,  1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 8'd0,  1'b1, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h4000, 8'd32, 1'b1, 1'b1, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h4000, 8'd64, 1'b1, 1'b1, 16'h0800};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'hC000, 8'd96, 1'b1, 1'b1, 16'hF000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h1234, 8'd96, 1'b1, 1'b0, 16'hF000};

    // Reset, idle pass-through at zero gain, and the first attack steps.
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rst, vecs[i].ns, vecs[i].tk, vecs[i].sin, 16'd3);
      check("vec_gain",  32'(gain),         32'(vecs[i].e_gain));
      check("vec_busy",  32'(busy),         32'(vecs[i].e_busy));
      check("vec_valid", 32'(sample_valid), 32'(vecs[i].e_valid));
      check("vec_out",   32'(sample_out),   32'(vecs[i].e_out));
    end

    // Full note from zero with sustain_count = 3.
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'd3);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'd3);
    for (int i = 1; i <= 8; i++) begin
      ticks(1, 16'd3);
      check("attack_gain", 32'(gain), (i < 8) ? 32'(32 * i) : 32'd255);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'hC000, 16'd3);
    check("scale_unity", 32'(sample_out), 32'h0000C040);
    check("decay_first", 32'(gain), 32'd247);
    for (int i = 2; i <= 12; i++) begin
      ticks(1, 16'd3);
      check("decay_gain", 32'(gain), (i < 12) ? 32'(255 - 8 * i) : 32'd160);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h7FFF, 16'd3);
    check("scale_sustain", 32'(sample_out), 32'h00004FFF);
    ticks(3, 16'd3);
    check("sustain_held", 32'(gain), 32'd160);
    check("sustain_busy", 32'(busy), 32'd1);
    done_pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      ticks(1, 16'd3);
      check("release_gain", 32'(gain), (i < 40) ? 32'(160 - 4 * i) : 32'd0);
    end
    check("release_done", 32'(done), 32'd1);
    check("release_idle", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'd3);
    check("done_dropped", 32'(done), 32'd0);
    check("done_once", 32'(done_pulses), 32'd1);

    // Retrigger in RELEASE at gain 100 keeps the gain.
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'd3);
    ticks(24, 16'd3);
    ticks(15, 16'd3);
    check("pre_retrig", 32'(gain), 32'd100);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'd3);
    check("retrig_gain", 32'(gain), 32'd100);
    ticks(1, 16'd3);
    check("retrig_step", 32'(gain), 32'd132);

    // note_start together with sample_tick in SUSTAIN: no step, sample still scaled.
    ticks(3 + 12 + 2, 16'd3);
    check("in_sustain", 32'(gain), 32'd160);
    cyc(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'd3);
    check("coinc_gain", 32'(gain), 32'd160);
    check("coinc_out",  32'(sample_out), 32'h00004FFF);
    check("coinc_valid", 32'(sample_valid), 32'd1);
    ticks(1, 16'd3);
    check("coinc_attack", 32'(gain), 32'd192);

    // Reset during a long sustain, then a note with sustain_count = 0.
    ticks(2 + 12, 16'd500);
    ticks(3, 16'd500);
    check("long_sustain", 32'(gain), 32'd160);
    done_pulses = 0;
    cyc(1'b1, 1'b1, 1'b1, 16'h7FFF, 16'd0);
    check("rst_gain",  32'(gain), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'd0);
    check("rst_no_done", 32'(done_pulses), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 16'd0);
    ticks(8 + 12, 16'd0);
    check("zero_sus_enter", 32'(gain), 32'd160);
    ticks(1, 16'd0);
    check("zero_sus_held", 32'(gain), 32'd160);
    ticks(1, 16'd0);
    check("zero_sus_release", 32'(gain), 32'd156);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 400) == 0, ($urandom % 300) == 0, 1'($urandom % 2),
          16'($urandom), 16'($urandom % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
